// File: rtl/line_trigger_scheduler_if.sv
// Handshake/bus bundle between the encoder front end, the line trigger scheduler
// and the readout sequencer. The scheduler sits on the slave side.
interface line_trigger_scheduler_if #(
    parameter int POS_W   = 16,
    parameter int DIV_W   = 12,
    parameter int LINES_W = 16,
    parameter int OVR_W   = 8
);
    logic               EN;
    logic [DIV_W-1:0]   CFG_DIV;
    logic [LINES_W-1:0] CFG_LINES;
    logic               STEP;
    logic               DIR;
    logic               TRIG_ACK;
    logic               TRIG_REQ;
    logic               OVERRUN;
    logic               SCAN_DONE;
    logic               BUSY;
    logic [POS_W-1:0]   POS;
    logic [LINES_W-1:0] LINE_CNT;
    logic [OVR_W-1:0]   OVR_CNT;

    modport master (
        output EN, CFG_DIV, CFG_LINES, STEP, DIR, TRIG_ACK,
        input  TRIG_REQ, OVERRUN, SCAN_DONE, BUSY, POS, LINE_CNT, OVR_CNT
    );

    modport slave (
        input  EN, CFG_DIV, CFG_LINES, STEP, DIR, TRIG_ACK,
        output TRIG_REQ, OVERRUN, SCAN_DONE, BUSY, POS, LINE_CNT, OVR_CNT
    );
endinterface

// File: rtl/line_trigger_scheduler.sv
// Turns encoder STEP/DIR events into one line-trigger request per CFG_DIV forward
// steps, absorbing reverse motion (backlash) so no line position is re-triggered.
module line_trigger_scheduler #(
    parameter int POS_W   = 16,
    parameter int DIV_W   = 12,
    parameter int LINES_W = 16,
    parameter int OVR_W   = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    line_trigger_scheduler_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DIV_W-1:0]   DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]   DIV_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]   POS_ZERO   = {POS_W{1'b0}};
    localparam logic [POS_W-1:0]   POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]   POS_MAX    = {POS_W{1'b1}};
    localparam logic [LINES_W-1:0] LINES_ZERO = {LINES_W{1'b0}};
    localparam logic [LINES_W-1:0] LINES_ONE  = {{(LINES_W-1){1'b0}}, 1'b1};
    localparam logic [OVR_W-1:0]   OVR_ZERO   = {OVR_W{1'b0}};
    localparam logic [OVR_W-1:0]   OVR_ONE    = {{(OVR_W-1){1'b0}}, 1'b1};
    localparam logic [OVR_W-1:0]   OVR_MAX    = {OVR_W{1'b1}};

    logic [1:0]         state_r;
    logic [DIV_W-1:0]   div_m1_r;
    logic [LINES_W-1:0] lines_r;
    logic [DIV_W-1:0]   phase_r;
    logic [POS_W-1:0]   backlog_r;
    logic [POS_W-1:0]   pos_r;
    logic [LINES_W-1:0] line_cnt_r;
    logic [OVR_W-1:0]   ovr_cnt_r;
    logic               trig_req_r;
    logic               overrun_r;
    logic               scan_done_r;
    logic               busy_r;

    logic step_fwd_s;
    logic step_rev_s;
    logic hs_s;
    logic trig_pt_s;
    logic limit_s;

    // Step qualification, handshake and trigger-point detection for the current cycle
    always_comb begin
        step_fwd_s = bus.STEP & bus.DIR;
        step_rev_s = bus.STEP & ~bus.DIR;
        hs_s       = trig_req_r & bus.TRIG_ACK;
        trig_pt_s  = step_fwd_s & (backlog_r == POS_ZERO) & (phase_r == div_m1_r);
        limit_s    = hs_s & (lines_r != LINES_ZERO) & ((line_cnt_r + LINES_ONE) == lines_r);
    end

    // Scan sequencer: state, position/backlash tracking, trigger handshake and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            div_m1_r    <= DIV_ZERO;
            lines_r     <= LINES_ZERO;
            phase_r     <= DIV_ZERO;
            backlog_r   <= POS_ZERO;
            pos_r       <= POS_ZERO;
            line_cnt_r  <= LINES_ZERO;
            ovr_cnt_r   <= OVR_ZERO;
            trig_req_r  <= 1'b0;
            overrun_r   <= 1'b0;
            scan_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            overrun_r   <= 1'b0;
            scan_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.EN) begin
                        state_r    <= ST_RUN;
                        busy_r     <= 1'b1;
                        div_m1_r   <= (bus.CFG_DIV == DIV_ZERO) ? DIV_ZERO : (bus.CFG_DIV - DIV_ONE);
                        lines_r    <= bus.CFG_LINES;
                        phase_r    <= DIV_ZERO;
                        backlog_r  <= POS_ZERO;
                        pos_r      <= POS_ZERO;
                        line_cnt_r <= LINES_ZERO;
                        ovr_cnt_r  <= OVR_ZERO;
                        trig_req_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.EN) begin
                        // Abort: the handshake on the wire still counts, the pending request is dropped
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        trig_req_r <= 1'b0;
                        if (hs_s) begin
                            line_cnt_r <= line_cnt_r + LINES_ONE;
                        end
                    end else begin
                        if (bus.STEP) begin
                            pos_r <= bus.DIR ? (pos_r + POS_ONE) : (pos_r - POS_ONE);
                        end
                        if (step_rev_s) begin
                            if (backlog_r != POS_MAX) begin
                                backlog_r <= backlog_r + POS_ONE;
                            end
                        end else if (step_fwd_s) begin
                            if (backlog_r != POS_ZERO) begin
                                backlog_r <= backlog_r - POS_ONE;
                            end else begin
                                phase_r <= (phase_r == div_m1_r) ? DIV_ZERO : (phase_r + DIV_ONE);
                            end
                        end
                        if (hs_s) begin
                            line_cnt_r <= line_cnt_r + LINES_ONE;
                        end
                        if (limit_s) begin
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            scan_done_r <= 1'b1;
                            trig_req_r  <= 1'b0;
                        end else if (trig_pt_s) begin
                            trig_req_r <= 1'b1;
                            if (trig_req_r && !bus.TRIG_ACK) begin
                                overrun_r <= 1'b1;
                                if (ovr_cnt_r != OVR_MAX) begin
                                    ovr_cnt_r <= ovr_cnt_r + OVR_ONE;
                                end
                            end
                        end else if (hs_s) begin
                            trig_req_r <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.EN) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    trig_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TRIG_REQ  = trig_req_r;
    assign bus.OVERRUN   = overrun_r;
    assign bus.SCAN_DONE = scan_done_r;
    assign bus.BUSY      = busy_r;
    assign bus.POS       = pos_r;
    assign bus.LINE_CNT  = line_cnt_r;
    assign bus.OVR_CNT   = ovr_cnt_r;
endmodule

// File: tb/tb_line_trigger_scheduler.sv
// Bench for line_trigger_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a high-water-mark position model.
module tb_line_trigger_scheduler;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    bit   ack_auto = 1'b0;

    line_trigger_scheduler_if #(.POS_W(16), .DIV_W(12), .LINES_W(16), .OVR_W(8)) bus ();

    line_trigger_scheduler #(.POS_W(16), .DIV_W(12), .LINES_W(16), .OVR_W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a trigger point is a forward step that raises the position
    // high-water mark of this scan onto a multiple of the divider.
    int m_st;
    int m_div, m_lines, m_net, m_hwm, m_line, m_ovr;
    bit m_req, m_ovp, m_donep, m_hs, m_tp, chk_en = 1'b0;

    always @(negedge CLK) begin
        if (chk_en) begin
            check("TRIG_REQ",  {31'd0, bus.TRIG_REQ},  {31'd0, m_req});
            check("OVERRUN",   {31'd0, bus.OVERRUN},   {31'd0, m_ovp});
            check("SCAN_DONE", {31'd0, bus.SCAN_DONE}, {31'd0, m_donep});
            check("BUSY",      {31'd0, bus.BUSY},      (m_st == 1) ? 32'd1 : 32'd0);
            check("POS",       {16'd0, bus.POS},       {16'd0, m_net[15:0]});
            check("LINE_CNT",  {16'd0, bus.LINE_CNT},  {16'd0, m_line[15:0]});
            check("OVR_CNT",   {24'd0, bus.OVR_CNT},   {24'd0, m_ovr[7:0]});
        end
        if (RST) begin
            m_st = 0; m_req = 0; m_ovp = 0; m_donep = 0;
            m_net = 0; m_hwm = 0; m_line = 0; m_ovr = 0; m_div = 1; m_lines = 0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            m_hs = m_req && bus.TRIG_ACK;
            m_ovp = 0; m_donep = 0;
            case (m_st)
                0: if (bus.EN) begin
                    m_st = 1;
                    m_div = (bus.CFG_DIV == 12'd0) ? 1 : int'(bus.CFG_DIV);
                    m_lines = int'(bus.CFG_LINES);
                    m_net = 0; m_hwm = 0; m_line = 0; m_ovr = 0; m_req = 0;
                end
                1: if (!bus.EN) begin
                    if (m_hs) m_line++;
                    m_req = 0; m_st = 0;
                end else begin
                    m_tp = 0;
                    if (bus.STEP) begin
                        if (bus.DIR) begin
                            m_net++;
                            if (m_net > m_hwm) begin
                                m_hwm = m_net;
                                m_tp = (m_hwm % m_div) == 0;
                            end
                        end else m_net--;
                    end
                    if (m_hs) m_line++;
                    if (m_hs && m_lines != 0 && m_line == m_lines) begin
                        m_st = 2; m_req = 0; m_donep = 1;
                    end else if (m_tp) begin
                        if (m_req && !m_hs) begin
                            m_ovp = 1;
                            if (m_ovr < 255) m_ovr++;
                        end
                        m_req = 1;
                    end else if (m_hs) m_req = 0;
                end
                default: if (!bus.EN) m_st = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
        if (ack_auto) bus.TRIG_ACK = bus.TRIG_REQ;
    endtask

    task automatic start(input logic [11:0] div, input logic [15:0] lines);
        bus.STEP = 1'b0; bus.TRIG_ACK = 1'b0; bus.EN = 1'b0;
        cyc();
        bus.CFG_DIV = div; bus.CFG_LINES = lines; bus.EN = 1'b1;
        cyc();
    endtask

    task automatic stp(input logic d);
        bus.STEP = 1'b1; bus.DIR = d;
        cyc();
        bus.STEP = 1'b0;
        cyc();
    endtask

    int done_cnt;

    initial begin
        RST = 1'b1;
        bus.EN = 1'b0; bus.CFG_DIV = 12'd0; bus.CFG_LINES = 16'd0;
        bus.STEP = 1'b0; bus.DIR = 1'b0; bus.TRIG_ACK = 1'b0;
        cyc(); cyc();
        RST = 1'b0;
        cyc();
        check("reset_busy", {31'd0, bus.BUSY}, 32'd0);
        check("reset_pos",  {16'd0, bus.POS},  32'd0);

        // Divide by 4, readout acknowledging one cycle after each request
        start(12'd4, 16'd0);
        ack_auto = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.STEP = 1'b1; bus.DIR = 1'b1;
            cyc();
            check("t1_req_after_step", {31'd0, bus.TRIG_REQ}, (i % 4 == 3) ? 32'd1 : 32'd0);
            bus.STEP = 1'b0;
            cyc(); cyc();
        end
        ack_auto = 1'b0; bus.TRIG_ACK = 1'b0;
        check("t1_line_cnt", {16'd0, bus.LINE_CNT}, 32'd3);
        check("t1_pos",      {16'd0, bus.POS},      32'd12);

        // Backlash: reverse steps are re-walked before the phase advances again
        start(12'd4, 16'd0);
        for (int i = 0; i < 3; i++) stp(1'b1);
        stp(1'b0); stp(1'b0);
        stp(1'b1); stp(1'b1);
        check("t2_no_req", {31'd0, bus.TRIG_REQ}, 32'd0);
        check("t2_pos3",   {16'd0, bus.POS},      32'd3);
        stp(1'b1);
        check("t2_req",    {31'd0, bus.TRIG_REQ}, 32'd1);
        check("t2_pos4",   {16'd0, bus.POS},      32'd4);

        // Divide by 1 with no readout acknowledge: every later point is an overrun
        start(12'd1, 16'd0);
        for (int i = 0; i < 5; i++) begin
            bus.STEP = 1'b1; bus.DIR = 1'b1;
            cyc();
            check("t3_overrun", {31'd0, bus.OVERRUN}, (i > 0) ? 32'd1 : 32'd0);
            bus.STEP = 1'b0;
            cyc();
        end
        check("t3_ovr_cnt", {24'd0, bus.OVR_CNT}, 32'd4);
        check("t3_req",     {31'd0, bus.TRIG_REQ}, 32'd1);

        // Acknowledge coinciding with the next trigger point keeps the request up
        start(12'd2, 16'd0);
        stp(1'b1); stp(1'b1); stp(1'b1);
        bus.STEP = 1'b1; bus.DIR = 1'b1; bus.TRIG_ACK = 1'b1;
        cyc();
        bus.STEP = 1'b0; bus.TRIG_ACK = 1'b0;
        cyc();
        check("t4_req",  {31'd0, bus.TRIG_REQ}, 32'd1);
        check("t4_line", {16'd0, bus.LINE_CNT}, 32'd1);
        check("t4_ovr",  {24'd0, bus.OVR_CNT},  32'd0);

        // Line limit of 3 with continuous steps and acknowledge
        start(12'd1, 16'd3);
        bus.STEP = 1'b1; bus.DIR = 1'b1; bus.TRIG_ACK = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            done_cnt += int'(bus.SCAN_DONE);
        end
        bus.STEP = 1'b0; bus.TRIG_ACK = 1'b0;
        check("t5_done_pulses", done_cnt,                 32'd1);
        check("t5_line",        {16'd0, bus.LINE_CNT},    32'd3);
        check("t5_pos_frozen",  {16'd0, bus.POS},         32'd4);
        check("t5_busy",        {31'd0, bus.BUSY},        32'd0);
        check("t5_req",         {31'd0, bus.TRIG_REQ},    32'd0);

        // Abort with a pending request, restart, then a mid-scan reset
        start(12'd1, 16'd0);
        stp(1'b1);
        check("t6_req_pending", {31'd0, bus.TRIG_REQ}, 32'd1);
        bus.EN = 1'b0;
        cyc();
        check("t6_req_dropped", {31'd0, bus.TRIG_REQ}, 32'd0);
        check("t6_pos_held",    {16'd0, bus.POS},      32'd1);
        bus.EN = 1'b1;
        cyc();
        check("t6_pos_cleared", {16'd0, bus.POS},      32'd0);
        check("t6_busy",        {31'd0, bus.BUSY},     32'd1);
        stp(1'b1); stp(1'b1); stp(1'b1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check("t6_rst_req",  {31'd0, bus.TRIG_REQ}, 32'd0);
        check("t6_rst_pos",  {16'd0, bus.POS},      32'd0);
        check("t6_rst_busy", {31'd0, bus.BUSY},     32'd0);
        check("t6_rst_line", {16'd0, bus.LINE_CNT}, 32'd0);

        // Randomized traffic, scored by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            RST           = ($urandom_range(0, 599) == 0);
            bus.EN        = ($urandom_range(0, 99) >= 3);
            bus.CFG_DIV   = 12'($urandom_range(0, 5));
            bus.CFG_LINES = 16'($urandom_range(0, 6));
            bus.STEP      = 1'($urandom_range(0, 1));
            bus.DIR       = ($urandom_range(0, 9) < 7);
            bus.TRIG_ACK  = ($urandom_range(0, 2) == 0);
            cyc();
        end
        RST = 1'b0; bus.STEP = 1'b0; bus.TRIG_ACK = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
